// File: rtl/i2c_bus_arbiter_if.sv
// Signal bundle between requesters, the bus arbiter and the shared i2c_master.
// master modport is the arbiter's view; slave modport is the requesters plus the i2c_master.
interface i2c_bus_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_REQ-1:0]      req;
   logic [7*NUM_REQ-1:0]    req_addr;
   logic [NUM_REQ-1:0]      req_rw;
   logic [32*NUM_REQ-1:0]   req_data_wr;
   logic [8*NUM_REQ-1:0]    req_nbytes;
   logic [NUM_REQ-1:0]      done;
   logic [31:0]             rd_data;
   logic                    ack_err;
   logic [IDX_W-1:0]        grant_idx;
   logic                    bus_active;
   logic                    m_ena;
   logic [6:0]              m_addr;
   logic                    m_rw;
   logic [31:0]             m_data_wr;
   logic [7:0]              m_nbytes;
   logic                    m_busy;
   logic [31:0]             m_data_rd;
   logic                    m_ack_error;

   modport master (
      input  req, req_addr, req_rw, req_data_wr, req_nbytes,
      input  m_busy, m_data_rd, m_ack_error,
      output done, rd_data, ack_err, grant_idx, bus_active,
      output m_ena, m_addr, m_rw, m_data_wr, m_nbytes
   );

   modport slave (
      output req, req_addr, req_rw, req_data_wr, req_nbytes,
      output m_busy, m_data_rd, m_ack_error,
      input  done, rd_data, ack_err, grant_idx, bus_active,
      input  m_ena, m_addr, m_rw, m_data_wr, m_nbytes
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters.
// Optional I2C_ARB_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on LAUNCH/WAIT_DONE.
//
// state     | meaning
// IDLE      | waiting for a request while the master is idle
// LAUNCH    | m_ena high until the master reports busy
// WAIT_DONE | master busy; capture results when busy drops
// COMPLETE  | pulse done to the granted requester, advance pointer
module i2c_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
`ifdef I2C_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
   input logic               clk,
   input logic               reset,
   i2c_bus_arbiter_if.master bus
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LAUNCH    = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;
   localparam logic [1:0] COMPLETE  = 2'd3;

   logic [1:0]         state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   grant_q;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] req_hi;
   logic [NUM_REQ-1:0] done_q;
   logic [31:0]        rd_data_q;
   logic               ack_err_q;
   logic               bus_active_q;
   logic               m_ena_q;
   logic [6:0]         m_addr_q;
   logic               m_rw_q;
   logic [31:0]        m_data_wr_q;
   logic [7:0]         m_nbytes_q;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [15:0]        tmo_cnt;
   logic [16:0]        tmo_nxt;

   assign tmo_nxt = {1'b0, tmo_cnt} + 17'd1;
`endif

   // Requests above the last grant win; otherwise wrap to the lowest set bit.
   always_comb begin
      hi_mask  = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         hi_mask[i] = (i > int'(last_grant));
      req_hi = bus.req & hi_mask;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            pick_idx = IDX_W'(i);
            pick_vld = 1'b1;
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_hi[i]) pick_idx = IDX_W'(i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= IDX_W'(NUM_REQ - 1);
         grant_q      <= '0;
         done_q       <= '0;
         rd_data_q    <= '0;
         ack_err_q    <= 1'b0;
         bus_active_q <= 1'b0;
         m_ena_q      <= 1'b0;
         m_addr_q     <= '0;
         m_rw_q       <= 1'b0;
         m_data_wr_q  <= '0;
         m_nbytes_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         done_q <= '0;
         case (state)
            IDLE: begin
               if (pick_vld && !bus.m_busy) begin
                  m_addr_q     <= bus.req_addr[7*pick_idx +: 7];
                  m_rw_q       <= bus.req_rw[pick_idx];
                  m_data_wr_q  <= bus.req_data_wr[32*pick_idx +: 32];
                  m_nbytes_q   <= bus.req_nbytes[8*pick_idx +: 8];
                  grant_q      <= pick_idx;
                  bus_active_q <= 1'b1;
                  state        <= LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
                  tmo_cnt      <= '0;
`endif
               end
            end
            LAUNCH: begin
               if (!m_ena_q) begin
                  m_ena_q <= 1'b1;
               end else if (bus.m_busy) begin
                  m_ena_q <= 1'b0;
                  state   <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!bus.m_busy) begin
                  rd_data_q <= bus.m_data_rd;
                  ack_err_q <= bus.m_ack_error;
                  state     <= COMPLETE;
               end
            end
            COMPLETE: begin
               done_q[grant_q] <= 1'b1;
               bus_active_q    <= 1'b0;
               last_grant      <= grant_q;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef I2C_ARB_TIMEOUT_EN
         // Watchdog overrides whatever LAUNCH/WAIT_DONE decided on this edge.
         if ((state == LAUNCH) || (state == WAIT_DONE)) begin
            tmo_cnt <= tmo_nxt[15:0];
            if (tmo_nxt == 17'(TIMEOUT_CYCLES)) begin
               m_ena_q   <= 1'b0;
               rd_data_q <= '0;
               ack_err_q <= 1'b1;
               state     <= COMPLETE;
            end
         end
`endif
      end
   end

   assign bus.done       = done_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.ack_err    = ack_err_q;
   assign bus.grant_idx  = grant_q;
   assign bus.bus_active = bus_active_q;
   assign bus.m_ena      = m_ena_q;
   assign bus.m_addr     = m_addr_q;
   assign bus.m_rw       = m_rw_q;
   assign bus.m_data_wr  = m_data_wr_q;
   assign bus.m_nbytes   = m_nbytes_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: timestamp-based transaction model plus directed scenarios.
module tb_i2c_bus_arbiter;
   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int NEVER   = 32'h3fff_ffff;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TMO     = 50;
   localparam int BUSY1   = 30;
`else
   localparam int BUSY1   = 100;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   i2c_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

   i2c_bus_arbiter #(
      .NUM_REQ(NUM_REQ),
      .IDX_W(IDX_W)
`ifdef I2C_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s at edge %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // Transaction model: when each milestone of the current transaction happened, by edge number.
   bit          mdl_ok = 1'b0;
   bit          in_txn;
   int          g_idx, last_g;
   int          t_grant, t_ack, t_end, t_done;
   logic [6:0]  x_addr;
   logic        x_rw;
   logic [31:0] x_data, x_rd;
   logic [7:0]  x_nb;
   logic        x_ack;

   always @(posedge clk) begin : model
      int  ii;
      bit  fnd;
      cyc++;
      if (reset) begin
         mdl_ok = 1'b1; in_txn = 1'b0; g_idx = 0; last_g = NUM_REQ - 1;
         t_grant = 0; t_ack = NEVER; t_end = NEVER; t_done = NEVER;
         x_addr = '0; x_rw = 1'b0; x_data = '0; x_nb = '0; x_rd = '0; x_ack = 1'b0;
      end else if (mdl_ok) begin
         if (!in_txn) begin
            if (bus.req != '0 && !bus.m_busy) begin
               fnd = 1'b0;
               for (int k = 1; k <= NUM_REQ; k++) begin
                  ii = (last_g + k) % NUM_REQ;
                  if (!fnd && bus.req[ii]) begin g_idx = ii; fnd = 1'b1; end
               end
               x_addr = bus.req_addr[7*g_idx +: 7];
               x_rw   = bus.req_rw[g_idx];
               x_data = bus.req_data_wr[32*g_idx +: 32];
               x_nb   = bus.req_nbytes[8*g_idx +: 8];
               in_txn = 1'b1; t_grant = cyc; t_ack = NEVER; t_end = NEVER;
            end
         end else if (t_end == NEVER) begin
`ifdef I2C_ARB_TIMEOUT_EN
            if (cyc - t_grant == TMO) begin
               t_end = cyc; x_rd = '0; x_ack = 1'b1;
            end else
`endif
            if (t_ack == NEVER) begin
               if (cyc >= t_grant + 2 && bus.m_busy) t_ack = cyc;
            end else if (!bus.m_busy) begin
               t_end = cyc; x_rd = bus.m_data_rd; x_ack = bus.m_ack_error;
            end
         end else begin
            t_done = cyc; last_g = g_idx; in_txn = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : compare
      if (mdl_ok) begin
         chk("bus_active", 32'(bus.bus_active), 32'(in_txn));
         chk("m_ena", 32'(bus.m_ena),
             32'(in_txn && cyc >= t_grant + 1 && t_ack == NEVER && t_end == NEVER));
         chk("done", 32'(bus.done), (t_done == cyc) ? (32'd1 << g_idx) : 32'd0);
         chk("grant_idx", 32'(bus.grant_idx), 32'(g_idx));
         chk("rd_data", bus.rd_data, x_rd);
         chk("ack_err", 32'(bus.ack_err), 32'(x_ack));
         chk("m_addr", 32'(bus.m_addr), 32'(x_addr));
         chk("m_rw", 32'(bus.m_rw), 32'(x_rw));
         chk("m_data_wr", bus.m_data_wr, x_data);
         chk("m_nbytes", 32'(bus.m_nbytes), 32'(x_nb));
      end
   end

   // i2c_master stand-in: busy rises mm_rise cycles after ena, lasts mm_len cycles.
   int          mm_rise = 0;
   int          mm_len  = 5;
   logic [31:0] mm_data = '0;
   logic        mm_err  = 1'b0;
   bit          mm_never = 1'b0;
   int          fall_cyc = 0;

   initial begin : master_model
      bus.m_busy = 1'b0; bus.m_data_rd = '0; bus.m_ack_error = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && bus.m_ena && !mm_never) begin
            for (int k = 0; k < mm_rise && !reset; k++) @(negedge clk);
            if (!reset) begin
               bus.m_busy = 1'b1;
               bus.m_data_rd = ~mm_data;
               for (int k = 0; k < mm_len && !reset; k++) @(negedge clk);
               bus.m_data_rd = mm_data;
               bus.m_ack_error = mm_err;
               bus.m_busy = 1'b0;
               fall_cyc = cyc;
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [6:0] a, input logic rw,
                          input logic [31:0] d, input logic [7:0] n);
      bus.req_addr[7*i +: 7]     = a;
      bus.req_rw[i]              = rw;
      bus.req_data_wr[32*i +: 32] = d;
      bus.req_nbytes[8*i +: 8]   = n;
   endtask

   task automatic wait_grant(output int gcyc, input string nm);
      int k = 0;
      gcyc = -1;
      while (k < 30 && gcyc < 0) begin
         @(negedge clk);
         if (bus.bus_active === 1'b1) gcyc = cyc;
         k++;
      end
      nvec++;
      if (gcyc < 0) begin
         nfail++;
         $display("FAIL %s: no grant within 30 cycles, bus_active=%b", nm, bus.bus_active);
      end
   endtask

   task automatic wait_done(output int dcyc, output logic [3:0] dv, input string nm);
      int k = 0;
      dcyc = -1; dv = '0;
      while (k < 300 && dcyc < 0) begin
         @(negedge clk);
         if (bus.done !== '0) begin dcyc = cyc; dv = bus.done; end
         k++;
      end
      nvec++;
      if (dcyc < 0) begin
         nfail++;
         $display("FAIL %s: no done within 300 cycles, done=%b", nm, bus.done);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, required below 200000", $time);
      $fatal(1);
   end

   initial begin : stim
      int          gc, dc, g_order[5];
      logic [3:0]  dv;
      bus.req = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_data_wr = '0; bus.req_nbytes = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_active", 32'(bus.bus_active), 0);
      chk("rst_ena", 32'(bus.m_ena), 0);
      reset = 1'b0;

      // single read from requester 0
      mm_rise = 2; mm_len = BUSY1; mm_data = 32'h00A1B2C3; mm_err = 1'b0;
      set_req(0, 7'h50, 1'b1, 32'h0, 8'd3);
      bus.req = 4'b0001;
      wait_grant(gc, "t1_grant");
      chk("t1_ena_at_grant", 32'(bus.m_ena), 0);
      chk("t1_gidx", 32'(bus.grant_idx), 0);
      chk("t1_addr", 32'(bus.m_addr), 32'h50);
      chk("t1_rw", 32'(bus.m_rw), 1);
      chk("t1_nbytes", 32'(bus.m_nbytes), 3);
      @(negedge clk);
      chk("t1_ena_plus1", 32'(bus.m_ena), 1);
      wait_done(dc, dv, "t1_done");
      bus.req = '0;
      chk("t1_done_vec", 32'(dv), 32'b0001);
      chk("t1_done_lat", 32'(dc - fall_cyc), 2);
      chk("t1_rd_data", bus.rd_data, 32'h00A1B2C3);
      chk("t1_ack_err", 32'(bus.ack_err), 0);
      @(negedge clk);
      chk("t1_done_1cyc", 32'(bus.done), 0);

      // all four requesting from reset
      do_reset();
      mm_rise = 1; mm_len = 5; mm_data = 32'h1234_5678;
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 7'(7'h10 + i), i[0], 32'hA000_0000 + 32'(i), 8'(i + 1));
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_grant(gc, "t2_grant");
         g_order[n] = int'(bus.grant_idx);
         wait_done(dc, dv, "t2_done");
         chk("t2_done_onehot", 32'(dv), 32'd1 << g_order[n]);
         if (n == 4) bus.req = '0;
      end
      chk("t2_order0", 32'(g_order[0]), 0);
      chk("t2_order1", 32'(g_order[1]), 1);
      chk("t2_order2", 32'(g_order[2]), 2);
      chk("t2_order3", 32'(g_order[3]), 3);
      chk("t2_order4", 32'(g_order[4]), 0);

      // requester 2 drops req one cycle after grant
      mm_rise = 0; mm_len = 8; mm_data = 32'h0000_0022;
      set_req(2, 7'h2A, 1'b1, 32'h0, 8'd2);
      bus.req = 4'b0100;
      wait_grant(gc, "t3_grant");
      chk("t3_gidx", 32'(bus.grant_idx), 2);
      @(negedge clk);
      bus.req = '0;
      set_req(2, 7'h11, 1'b0, 32'hFFFF_FFFF, 8'd9);
      wait_done(dc, dv, "t3_done");
      chk("t3_done_vec", 32'(dv), 32'b0100);
      chk("t3_addr_held", 32'(bus.m_addr), 32'h2A);

      // requester 1 write with ack error, then requester 3 normally
      mm_err = 1'b1; mm_data = 32'h0;
      set_req(1, 7'h3C, 1'b0, 32'hCAFE_F00D, 8'd4);
      bus.req = 4'b0010;
      wait_grant(gc, "t4_grant");
      wait_done(dc, dv, "t4_done");
      bus.req = '0;
      chk("t4_done_vec", 32'(dv), 32'b0010);
      chk("t4_ack_err", 32'(bus.ack_err), 1);
      mm_err = 1'b0; mm_data = 32'h0000_0055;
      set_req(3, 7'h41, 1'b1, 32'h0, 8'd1);
      bus.req = 4'b1000;
      wait_grant(gc, "t4b_grant");
      chk("t4b_gidx", 32'(bus.grant_idx), 3);
      wait_done(dc, dv, "t4b_done");
      bus.req = '0;
      chk("t4b_done_vec", 32'(dv), 32'b1000);
      chk("t4b_ack_err", 32'(bus.ack_err), 0);
      chk("t4b_rd_data", bus.rd_data, 32'h55);

      // reset during WAIT_DONE
      mm_rise = 0; mm_len = 20; mm_data = 32'h0BAD_CAFE;
      set_req(0, 7'h50, 1'b1, 32'h0, 8'd3);
      bus.req = 4'b0001;
      wait_grant(gc, "t5_grant");
      for (int k = 0; k < 10 && !(bus.m_busy && !bus.m_ena); k++) @(negedge clk);
      chk("t5_in_wait", 32'(bus.m_busy && !bus.m_ena && bus.bus_active), 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_rst_active", 32'(bus.bus_active), 0);
      chk("t5_rst_ena", 32'(bus.m_ena), 0);
      chk("t5_rst_done", 32'(bus.done), 0);
      chk("t5_rst_rd", bus.rd_data, 0);
      chk("t5_rst_addr", 32'(bus.m_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      wait_grant(gc, "t5_regrant");
      chk("t5_regrant_idx", 32'(bus.grant_idx), 0);
      wait_done(dc, dv, "t5_done");
      bus.req = '0;
      chk("t5_done_vec", 32'(dv), 32'b0001);
      chk("t5_rd_data", bus.rd_data, 32'h0BAD_CAFE);

`ifdef I2C_ARB_TIMEOUT_EN
      // master never answers
      mm_never = 1'b1;
      bus.req = 4'b0001;
      wait_grant(gc, "t6_grant");
      wait_done(dc, dv, "t6_done");
      bus.req = '0;
      chk("t6_done_vec", 32'(dv), 32'b0001);
      chk("t6_latency", 32'(dc - gc), 32'(TMO + 1));
      chk("t6_ack_err", 32'(bus.ack_err), 1);
      chk("t6_rd_data", bus.rd_data, 0);
      mm_never = 1'b0;
`endif

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares one i2c_master instance between NUM_REQ independent requesters, e.g. the EEPROM reader and sensor pollers.
- Grants the bus round-robin and latches the winner's transaction descriptor.
- Drives the master's ena/addr/rw/data_wr/number_of_bytes and tracks busy to completion.
- Returns data_rd/ack_error with a one-cycle done pulse to the granted requester.
- Sits between requester blocks and the single i2c_master on the board's SDA/SCL pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index (clog2(NUM_REQ), min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester transaction request, level
req_addr  in  7*NUM_REQ  7-bit slave address per requester, slice i = [7i+6:7i]
req_rw  in  NUM_REQ  0 write, 1 read
req_data_wr  in  32*NUM_REQ  write data per requester, MSB byte sent first
req_nbytes  in  8*NUM_REQ  byte count per requester
done  out  NUM_REQ  one-cycle completion pulse, one-hot
rd_data  out  32  read data of last completed transaction
ack_err  out  1  error status of last completed transaction
grant_idx  out  IDX_W  index of current/last granted requester
bus_active  out  1  high from grant until done pulse
m_ena  out  1  to i2c_master ena
m_addr  out  7  to i2c_master addr
m_rw  out  1  to i2c_master rw
m_data_wr  out  32  to i2c_master data_wr
m_nbytes  out  8  to i2c_master number_of_bytes
m_busy  in  1  from i2c_master busy
m_data_rd  in  32  from i2c_master data_rd
m_ack_error  in  1  from i2c_master ack_error

Behaviour:
- Reset values:
  - all outputs 0.
  - state IDLE.
  - last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT_DONE, COMPLETE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from last_grant+1 with wrap-around.
  - In the same edge: latch that requester's addr/rw/data_wr/nbytes into m_* registers, set grant_idx, set bus_active=1, go to LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH:
  - m_ena=1.
  - Hold until m_busy is sampled 1, then deassert m_ena the following cycle and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for m_busy=0.
  - On that cycle capture m_data_rd into rd_data and m_ack_error into ack_err, then go to COMPLETE.
- COMPLETE:
  - done[grant_idx]=1 for exactly one cycle.
  - bus_active=0, last_grant=grant_idx, go to IDLE.
- Latency: grant edge to m_ena high is 1 cycle. m_busy falling to done pulse is 2 cycles.
- Requester rules:
  - A requester holds req until its done.
  - Dropping req after grant does not abort the transaction; it completes and done still pulses.
  - Dropping req before grant means the requester is not considered.
- Fairness: a requester that re-raises req immediately after its done is served only after every other pending requester.
- m_* descriptor registers stay stable from grant through COMPLETE. Requester inputs may change freely after grant.
- rd_data/ack_err hold their value until the next COMPLETE.
- Simultaneous requests: resolved purely by the round-robin pointer, with no fixed priority.
- m_busy already high in IDLE (master still finishing): no grant until m_busy=0.
- Reset mid-transaction: FSM returns to IDLE, m_ena=0, no done pulse. The master is reset by its own reset_n, driven from ~reset at top level.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN; adds parameter TIMEOUT_CYCLES, default 65535.
- With the macro defined:
  - A 16-bit counter clears on grant and increments in LAUNCH and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: go to COMPLETE with ack_err=1, rd_data=32'h0, m_ena=0. done still pulses.
- Without the macro: no counter, and the arbiter waits indefinitely on m_busy.

Test Plan:
- Single request: req=4'b0001, addr 7'h50, rw=1, nbytes=3, master model busy 1→0 after 100 cycles with data 32'h00A1B2C3 → m_ena high 1 cycle after grant; done=4'b0001 exactly 2 cycles after busy falls; rd_data=32'h00A1B2C3, ack_err=0.
- All four requesting continuously from reset → grant order 0,1,2,3,0; one done pulse per transaction; no back-to-back grant to the same index.
- Requester 2 drops req one cycle after grant → transaction runs to completion; done[2] pulses; m_addr unchanged throughout.
- Master returns ack_error=1 for requester 1's write → done[1] pulses with ack_err=1; next grant proceeds normally.
- reset asserted during WAIT_DONE → next cycle: state IDLE, all outputs 0, no done pulse; with req=4'b0001 held, first grant after reset goes to requester 0.
- With I2C_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=50, master never raises busy → done pulses after 50 cycles with ack_err=1, rd_data=0.
